// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_WR write and NUM_RD read channels
// onto a single SRAM command port. Read data returns in command order and
// is steered back to the issuing read channel through a small tag FIFO.
module sram_rr_arbiter #(
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int TAG_DEPTH  = 4,
  localparam int N  = NUM_WR + NUM_RD,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1,
  localparam int CW = $clog2(TAG_DEPTH) + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_WR-1:0]            wr_valid,
  output logic [NUM_WR-1:0]            wr_ready,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WR*MASK_WIDTH-1:0] wr_mask,
  input  logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_dout_valid,
  output logic [DATA_WIDTH-1:0]        rd_dout,
  output logic                         sram_addr_valid,
  input  logic                         sram_ready,
  output logic [ADDR_WIDTH-1:0]        sram_addr,
  output logic                         sram_write_en,
  output logic [DATA_WIDTH-1:0]        sram_data_in,
  output logic [MASK_WIDTH-1:0]        sram_write_mask,
  input  logic [DATA_WIDTH-1:0]        sram_data_out,
  input  logic                         sram_data_out_valid,
  output logic [IW-1:0]                grant_id,
  output logic                         grant_valid,
  output logic [CW-1:0]                outstanding,
  output logic                         unexpected_data
);

  localparam int TW = $clog2(TAG_DEPTH);

  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [N-1:0]  elig;
  logic          any_elig;
  logic          issue;
  logic          push;
  logic          pop;
  logic [RW-1:0] push_tag;
  logic [RW-1:0] head;

  logic [RW-1:0] tag_mem [TAG_DEPTH];
  logic [TW-1:0] tag_wr_ptr;
  logic [TW-1:0] tag_rd_ptr;
  logic [CW-1:0] tag_count;

  // Eligibility: reads additionally need a free tag slot; a same-cycle pop
  // deliberately does not count, which keeps the FIFO from ever overflowing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    elig = '0;
    for (int i = 0; i < NUM_WR; i++) elig[i] = wr_valid[i];
    for (int j = 0; j < NUM_RD; j++)
      elig[NUM_WR+j] = rd_valid[j] && (tag_count < CW'(TAG_DEPTH));
  end

  // Pick the first eligible channel at or after ptr; scanning from the far
  // end leaves the nearest hit as the final assignment.
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (elig[idx]) begin
        any_elig = 1'b1;
        sel      = IW'(idx);
      end
    end
  end

  assign sram_addr_valid = any_elig;
  assign issue           = any_elig && sram_ready && !reset;
  assign push            = issue && (sel >= IW'(NUM_WR));
  assign push_tag        = RW'(sel - IW'(NUM_WR));
  assign head            = tag_mem[tag_rd_ptr];
  assign pop             = sram_data_out_valid && (tag_count != '0) && !reset;
  assign rd_dout         = sram_data_out;
  assign outstanding     = tag_count;

  // Command mux from the selected channel; reads carry a zero mask.
  always_comb begin
    sram_addr       = '0;
    sram_write_en   = 1'b0;
    sram_data_in    = '0;
    sram_write_mask = '0;
    if (any_elig) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (sel == IW'(i)) begin
          sram_addr       = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          sram_write_en   = 1'b1;
          sram_data_in    = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
          sram_write_mask = wr_mask[i*MASK_WIDTH +: MASK_WIDTH];
        end
      end
      for (int j = 0; j < NUM_RD; j++) begin
        if (sel == IW'(NUM_WR + j)) sram_addr = rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Handshakes: only the issuing channel sees ready; returns go to the head tag.
  always_comb begin
    wr_ready      = '0;
    rd_ready      = '0;
    rd_dout_valid = '0;
    for (int i = 0; i < NUM_WR; i++) wr_ready[i] = issue && (sel == IW'(i));
    for (int j = 0; j < NUM_RD; j++) begin
      rd_ready[j]      = issue && (sel == IW'(NUM_WR + j));
      rd_dout_valid[j] = pop && (head == RW'(j));
    end
  end

  // Arbitration pointer, grant report, tag FIFO bookkeeping and error flag.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      ptr             <= '0;
      grant_id        <= '0;
      grant_valid     <= 1'b0;
      tag_wr_ptr      <= '0;
      tag_rd_ptr      <= '0;
      tag_count       <= '0;
      unexpected_data <= 1'b0;
    end else begin
      grant_valid <= issue;
      if (issue) begin
        grant_id <= sel;
        ptr      <= (int'(sel) == N - 1) ? '0 : sel + 1'b1;
      end
      if (push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
      if (sram_data_out_valid && (tag_count == '0)) unexpected_data <= 1'b1;
    end
  end

  // Tag storage written on every read issue.
  always_ff @(posedge clock) begin
    // NOTE: tag storage is not reset; the pointers and count alone define which entries are live.
    if (push) tag_mem[tag_wr_ptr] <= push_tag;
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter at default parameters (2 write, 2 read
// channels, 4 tags). Inputs change 1 ns after a rising edge; combinational
// outputs are checked just before the next edge, registered ones just after.
module tb_sram_rr_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  wr_valid, wr_ready;
  logic [37:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic [1:0]  rd_valid, rd_ready;
  logic [37:0] rd_addr;
  logic [1:0]  rd_dout_valid;
  logic [31:0] rd_dout;
  logic        sram_addr_valid;
  logic        sram_ready;
  logic [18:0] sram_addr;
  logic        sram_write_en;
  logic [31:0] sram_data_in;
  logic [3:0]  sram_write_mask;
  logic [31:0] sram_data_out;
  logic        sram_data_out_valid;
  logic [1:0]  grant_id;
  logic        grant_valid;
  logic [2:0]  outstanding;
  logic        unexpected_data;

  int checks   = 0;
  int failures = 0;
  int tb_out   = 0;

  sram_rr_arbiter dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_dout_valid(rd_dout_valid), .rd_dout(rd_dout),
    .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready),
    .sram_addr(sram_addr), .sram_write_en(sram_write_en),
    .sram_data_in(sram_data_in), .sram_write_mask(sram_write_mask),
    .sram_data_out(sram_data_out), .sram_data_out_valid(sram_data_out_valid),
    .grant_id(grant_id), .grant_valid(grant_valid),
    .outstanding(outstanding), .unexpected_data(unexpected_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Request vector: bits 1:0 are write channels, bits 3:2 are read channels.
  task automatic set_req(input logic [3:0] v);
    wr_valid = v[1:0];
    rd_valid = v[3:2];
  endtask

  function automatic logic [3:0] ready_vec();
    return {rd_ready, wr_ready};
  endfunction

  // Channel addresses used throughout: writes 0x100/0x101, reads 0x200/0x201.
  localparam logic [18:0] WA [2] = '{19'h100, 19'h101};
  localparam logic [18:0] RA [2] = '{19'h200, 19'h201};

  initial begin
    logic [3:0] exp_rdy;
    reset = 1'b1;
    set_req(4'b0000);
    sram_ready = 1'b1;
    sram_data_out = '0;
    sram_data_out_valid = 1'b0;
    wr_addr = {WA[1], WA[0]};
    wr_data = {32'hD1D1_0001, 32'hD0D0_0000};
    wr_mask = {4'h3, 4'hC};
    rd_addr = {RA[1], RA[0]};
    tick();
    tick();

    // All four channels held: strict 0,1,2,3 rotation; reads return 2 cycles later.
    for (int k = 0; k < 10; k++) begin
      reset = 1'b0;
      set_req(k < 8 ? 4'b1111 : 4'b0000);
      sram_data_out_valid = (k == 4 || k == 5 || k == 8 || k == 9);
      sram_data_out = 32'h1000 + 32'(k);
      #1;
      if (k == 0) begin
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_grant_valid", 64'(grant_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_unexpected", 64'(unexpected_data), 64'd0);
        check("w0_addr", 64'(sram_addr), 64'(WA[0]));
        check("w0_we", 64'(sram_write_en), 64'd1);
        check("w0_data", 64'(sram_data_in), 64'hD0D0_0000);
        check("w0_mask", 64'(sram_write_mask), 64'hC);
      end
      if (k == 2) check("r0_mask_zero", 64'(sram_write_mask), 64'd0);
      exp_rdy = (k < 8) ? 4'(4'b0001 << (k % 4)) : 4'b0000;
      check("rot_ready", 64'(ready_vec()), 64'(exp_rdy));
      case (k)
        4, 8:    check("rot_dout_valid", 64'(rd_dout_valid), 64'b01);
        5, 9:    check("rot_dout_valid", 64'(rd_dout_valid), 64'b10);
        default: check("rot_dout_valid", 64'(rd_dout_valid), 64'b00);
      endcase
      if (sram_data_out_valid) check("rot_dout", 64'(rd_dout), 64'h1000 + 64'(k));
      tick();
      if (k < 8) begin
        check("rot_grant_id", 64'(grant_id), 64'(k % 4));
        check("rot_grant_valid", 64'(grant_valid), 64'd1);
      end else begin
        check("rot_idle_gv", 64'(grant_valid), 64'd0);
      end
    end
    sram_data_out_valid = 1'b0;
    check("rot_outstanding_end", 64'(outstanding), 64'd0);
    check("rot_unexpected_end", 64'(unexpected_data), 64'd0);

    // Lone requester transitions i -> j for every pair; each read beat returns next cycle.
    tb_out = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        for (int p = 0; p < 2; p++) begin
          int ch;
          ch = (p == 0) ? i : j;
          set_req(4'(4'b0001 << ch));
          sram_data_out_valid = (tb_out > 0);
          #1;
          check("pair_ready", 64'(ready_vec()), 64'(4'b0001 << ch));
          tick();
          check("pair_grant_id", 64'(grant_id), 64'(ch));
          tb_out = tb_out + ((ch >= 2) ? 1 : 0) - (sram_data_out_valid ? 1 : 0);
        end
      end
    end
    set_req(4'b0000);
    sram_data_out_valid = (tb_out > 0);
    tick();
    sram_data_out_valid = 1'b0;
    check("pair_outstanding_end", 64'(outstanding), 64'd0);

    // Reads only with no returns: four issues (tags 0,1,0,1), then blocked.
    set_req(4'b1100);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fill_rd_ready", 64'(rd_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
      tick();
    end
    check("fill_outstanding", 64'(outstanding), 64'd4);
    #1;
    check("full_rd_ready", 64'(rd_ready), 64'b00);
    check("full_cmd_valid", 64'(sram_addr_valid), 64'd0);
    tick();
    check("full_gv", 64'(grant_valid), 64'd0);
    sram_data_out_valid = 1'b1;
    sram_data_out = 32'h5555_0000;
    #1;
    check("full_pop_no_free", 64'(rd_ready), 64'b00);
    check("full_pop_dv", 64'(rd_dout_valid), 64'b01);
    tick();
    check("after_pop_outstanding", 64'(outstanding), 64'd3);
    sram_data_out_valid = 1'b0;
    #1;
    check("resume_rd_ready", 64'(rd_ready), 64'b01);
    tick();
    check("resume_outstanding", 64'(outstanding), 64'd4);
    set_req(4'b0000);
    for (int k = 0; k < 4; k++) begin
      sram_data_out_valid = 1'b1;
      #1;
      check("drain_dv", 64'(rd_dout_valid), (k % 2 == 0) ? 64'b10 : 64'b01);
      tick();
    end
    sram_data_out_valid = 1'b0;
    check("drain_outstanding", 64'(outstanding), 64'd0);

    // Stall: all valid, SRAM not ready for 3 cycles; ptr sits at channel 3.
    set_req(4'b1111);
    sram_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 64'(ready_vec()), 64'd0);
      check("stall_cmd_valid", 64'(sram_addr_valid), 64'd1);
      check("stall_addr", 64'(sram_addr), 64'(RA[1]));
      check("stall_we", 64'(sram_write_en), 64'd0);
      tick();
      check("stall_gv", 64'(grant_valid), 64'd0);
    end
    sram_ready = 1'b1;
    tick();
    check("resume_grant_a", 64'(grant_id), 64'd3);
    tick();
    check("resume_grant_b", 64'(grant_id), 64'd0);
    set_req(4'b0000);
    sram_data_out_valid = 1'b1;
    #1;
    check("stall_return_dv", 64'(rd_dout_valid), 64'b10);
    tick();
    sram_data_out_valid = 1'b0;

    // In-order return to the issuing channel, then a beat with nothing in flight.
    set_req(4'b1000);
    rd_addr = {19'h10, 19'h20};
    #1;
    check("ord_addr_ch1", 64'(sram_addr), 64'h10);
    tick();
    set_req(4'b0100);
    #1;
    check("ord_addr_ch0", 64'(sram_addr), 64'h20);
    tick();
    set_req(4'b0000);
    sram_data_out_valid = 1'b1;
    sram_data_out = 32'hAAAA;
    #1;
    check("ord_dv_a", 64'(rd_dout_valid), 64'b10);
    check("ord_dout_a", 64'(rd_dout), 64'hAAAA);
    tick();
    sram_data_out = 32'hBBBB;
    #1;
    check("ord_dv_b", 64'(rd_dout_valid), 64'b01);
    check("ord_dout_b", 64'(rd_dout), 64'hBBBB);
    tick();
    check("ord_no_unexpected", 64'(unexpected_data), 64'd0);
    sram_data_out = 32'hCCCC;
    #1;
    check("empty_beat_dv", 64'(rd_dout_valid), 64'b00);
    tick();
    sram_data_out_valid = 1'b0;
    check("unexpected_set", 64'(unexpected_data), 64'd1);
    tick();
    tick();
    check("unexpected_sticky", 64'(unexpected_data), 64'd1);

    // Reset clears the flag; then reset with two reads in flight drops their tags.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_clears_unexpected", 64'(unexpected_data), 64'd0);
    rd_addr = {RA[1], RA[0]};
    set_req(4'b1100);
    tick();
    tick();
    check("pre_reset_outstanding", 64'(outstanding), 64'd2);
    reset = 1'b1;
    sram_data_out_valid = 1'b1;
    #1;
    check("reset_ready_zero", 64'(ready_vec()), 64'd0);
    check("reset_dv_zero", 64'(rd_dout_valid), 64'd0);
    tick();
    reset = 1'b0;
    set_req(4'b0000);
    check("post_reset_outstanding", 64'(outstanding), 64'd0);
    check("post_reset_gv", 64'(grant_valid), 64'd0);
    check("post_reset_unexpected", 64'(unexpected_data), 64'd0);
    #1;
    check("late_beat_dv", 64'(rd_dout_valid), 64'b00);
    tick();
    sram_data_out_valid = 1'b0;
    check("late_beat_unexpected", 64'(unexpected_data), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Parametrised round-robin arbiter that multiplexes NUM_WR write channels and NUM_RD read channels onto one SRAM command port.
- Returns read data in order to the channel that issued each read, using an internal tag FIFO.
- Successor to the fixed 4-port, multi-clock SRAM arbiter. Runs in one clock domain; CDC FIFOs sit outside this block.

Parameters:
- NUM_WR, 2, number of write channels
- NUM_RD, 2, number of read channels
- ADDR_WIDTH, 19, SRAM word address width
- DATA_WIDTH, 32, SRAM data width
- MASK_WIDTH, 4, write byte-mask width
- TAG_DEPTH, 4, maximum outstanding reads (power of 2, ≥2)
- Derived: N = NUM_WR+NUM_RD; IW = max(1, clog2(N)); RW = max(1, clog2(NUM_RD))

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- wr_valid  in  NUM_WR  write request per channel
- wr_ready  out  NUM_WR  write accepted this cycle
- wr_addr  in  NUM_WR*ADDR_WIDTH  packed, channel 0 in LSBs
- wr_data  in  NUM_WR*DATA_WIDTH  packed
- wr_mask  in  NUM_WR*MASK_WIDTH  packed
- rd_valid  in  NUM_RD  read request per channel
- rd_ready  out  NUM_RD  read accepted this cycle
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed
- rd_dout_valid  out  NUM_RD  one-hot, return data for that channel
- rd_dout  out  DATA_WIDTH  return data, shared by all read channels
- sram_addr_valid  out  1  command valid
- sram_ready  in  1  SRAM accepts a command
- sram_addr  out  ADDR_WIDTH  command address
- sram_write_en  out  1  1 = write, 0 = read
- sram_data_in  out  DATA_WIDTH  write data
- sram_write_mask  out  MASK_WIDTH  write mask; forced to 0 on reads
- sram_data_out  in  DATA_WIDTH  read data from SRAM
- sram_data_out_valid  in  1  read data valid, returned in command order
- grant_id  out  IW  channel index of the last issued command
- grant_valid  out  1  pulses 1 the cycle after an issue
- outstanding  out  clog2(TAG_DEPTH)+1  reads in flight
- unexpected_data  out  1  sticky error flag

Behaviour:
- Channel indexing: writes are 0..NUM_WR-1; reads are NUM_WR..N-1.
- Eligibility: a write channel is eligible when its valid is 1. A read channel is eligible when its valid is 1 and outstanding < TAG_DEPTH. A pop in the same cycle does not free a slot.
- Selection (combinational):
  - Choose the first eligible channel at or after ptr, wrapping modulo N.
  - sram_addr_valid = any channel eligible.
  - sram_addr, sram_write_en, sram_data_in and sram_write_mask come from the selected channel.
  - With no channel eligible, command outputs are 0.
- Issue: occurs when sram_addr_valid & sram_ready in the same cycle. Zero-latency handshake.
  - Only the selected channel's ready is asserted, equal to sram_ready.
  - All other readies are 0.
  - A ready is never asserted without its matching valid.
- On issue (registered):
  - ptr <= (sel+1) mod N
  - grant_id <= sel
  - grant_valid <= 1
- With no issue: ptr and grant_id hold; grant_valid <= 0.
- Fairness:
  - All N channels continuously valid → grant_id sequence 0,1,…,N-1,0,… with one issue per cycle while sram_ready=1.
  - A lone requester is granted every cycle.
- Stall: sram_ready=0 issues nothing, holds ptr, and leaves the selected request presented.
- Tag FIFO:
  - On a read issue, push (sel-NUM_WR).
  - On sram_data_out_valid with the FIFO non-empty: pop the head, set rd_dout_valid[head]=1 in the same cycle (combinational), and drive rd_dout=sram_data_out.
  - rd_dout_valid is 0 otherwise. rd_dout = sram_data_out always.
  - Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo TAG_DEPTH.
  - Read consumers have no backpressure and must accept return data.
- sram_data_out_valid while the FIFO is empty: data is dropped and unexpected_data <= 1, held until reset.
- Reset values (synchronous, applied at the clock edge):
  - ptr=0, grant_id=0, grant_valid=0, FIFO empty, outstanding=0, unexpected_data=0
  - ready and rd_dout_valid outputs are 0 during reset
- Reset during outstanding reads: tags are discarded. Any late return after reset sets unexpected_data, so the system must quiesce the SRAM first.
- N=1 is legal: grant_id is always 0.

Test Plan:
- Defaults, all 4 valid held after reset, sram_ready=1, 8 cycles → grant_id 0,1,2,3,0,1,2,3. With read data returned 2 cycles later, the read issues produce rd_dout_valid 01,10,01,10.
- Single requester per channel, for each pair (i, j): hold only channel i for 1 cycle, then only j → grant_id=i then j. Covers all 16 transitions.
- Reads only, sram_data_out_valid held 0 → rd_ready pulses 4 times, outstanding=4, then rd_ready=0. After one data beat returns, outstanding=3 and reads resume the following cycle.
- All valid, sram_ready=0 for 3 cycles then 1 → no ready, ptr held during the stall, then grant resumes at the pre-stall channel.
- Read ch1 addr 0x10, then ch0 addr 0x20; return 0xAAAA then 0xBBBB → rd_dout_valid=10 with 0xAAAA, then 01 with 0xBBBB. Then inject a beat with the FIFO empty → unexpected_data=1, cleared only by reset.
- Two reads in flight, assert reset 1 cycle → outstanding=0, grant_valid=0; a later data beat sets unexpected_data.
